audio_dac_serializer: RTL
=========================

// Module: audio_dac_serializer
// PURPOSE
//   Transmit side of the codec audio path: accepts packed stereo words (left [31:16], right [15:0])
//   from the filter/effect chain and shifts them out MSB-first on AUD_DACDAT in I2S format.
//   Runs in the Clk domain; AUD_BCLK/AUD_DACLRCK are codec-mastered inputs, synchronised and edge-detected.
//   A one-word holding buffer with valid/ready decouples the processing chain from frame timing.
// PARAMETERS
//   CH_W        16  bits per channel; word width = 2*CH_W
//   SYNC_STAGES 2   flip-flops in each BCLK/LRCK synchroniser (>=2)
// PORTS
//   Clk           in   1       system clock; must be >= 4x AUD_BCLK
//   reset         in   1       asynchronous, active-low reset
//   AUD_BCLK      in   1       codec bit clock (async to Clk)
//   AUD_DACLRCK   in   1       codec DAC frame clock; low = left channel, high = right
//   sample_in     in   2*CH_W  packed stereo sample, left in upper half
//   sample_valid  in   1       sample_in valid
//   sample_ready  out  1       holding buffer empty; transfer when valid && ready
//   AUD_DACDAT    out  1       serial DAC data
//   frame_start   out  1       1-Clk pulse when a word is moved to the shifter (left edge)
//   underrun      out  1       1-Clk pulse when a left edge finds the holding buffer empty
// BEHAVIOUR
//   Reset values: AUD_DACDAT=0, sample_ready=1, frame_start=0, underrun=0, state=IDLE, all regs 0.
//   Sync: BCLK and LRCK each pass SYNC_STAGES flops, then 1 flop for edge detect; all events are
//     delayed SYNC_STAGES+1 Clk from the pin. bfall = BCLK 1->0, lfall/lrise = LRCK 1->0 / 0->1.
//   Holding buffer: accept on sample_valid && sample_ready; sample_ready=0 the next cycle until emptied.
//     sample_in must be held by the sender while valid && !ready.
//   lfall (left start): if buffer full -> frame_reg <= buffer, buffer emptied, frame_start pulse,
//     sample_ready=1 the next Clk. If empty -> frame_reg <= 0, underrun pulse.
//     The load uses buffer contents from before this cycle; a same-cycle accept stays for the next frame.
//   Shifter: lfall loads shift_reg <= frame_reg_next[2*CH_W-1:CH_W]; lrise loads shift_reg <= frame_reg[CH_W-1:0].
//   FSM (advances only on sync'd events):
//     IDLE     : AUD_DACDAT=0; lrise ignored; lfall -> WAIT_MSB (performs left load).
//     WAIT_MSB : I2S one-BCLK delay; next bfall drives MSB, bit_cnt=1 -> SHIFT.
//     SHIFT    : each bfall drives next bit, bit_cnt++; after bit CH_W driven, the following bfall drives 0 -> PAD.
//     PAD      : AUD_DACDAT=0 until next LRCK edge.
//     Any lfall/lrise in WAIT_MSB/SHIFT/PAD -> reload shifter for that channel, bit_cnt=0 -> WAIT_MSB.
//   Precedence: an LRCK edge coincident with bfall wins; that bfall does not shift; MSB on the next bfall.
//   Short frame (LRCK edge before CH_W bits): remaining bits dropped, no flag; new channel starts clean.
//   Long frame: pad with 0 indefinitely; bit_cnt saturates at CH_W+1.
//   AUD_DACDAT is registered; it changes only on a bfall-qualified Clk edge (or reset/LRCK edge -> 0).
//   Reset mid-frame: AUD_DACDAT=0 and buffer cleared immediately; after release, stay in IDLE until lfall.
// TESTING
//   Bench: Clk = 8x BCLK, 32 BCLK per channel; check AUD_DACDAT at each BCLK rising edge.
//   1 Push 0xA5C3_1234 before lfall -> left bits 1010_0101_1100_0011 starting 2nd BCLK rise of left half,
//     then 15 zeros; right half carries 0x1234; frame_start pulses once.
//   2 No push before lfall -> underrun 1-Clk pulse, all 64 bits 0, sample_ready stays 1, frame_start 0.
//   3 Push 0x1111_2222 then hold valid with 0x3333_4444 -> ready low until lfall, high 1 Clk after load;
//     frames 1/2 carry 0x1111/0x2222 then 0x3333/0x4444.
//   4 LRCK edge on the same BCLK fall as a data bit -> no bit skipped or repeated (MSB on the next fall).
//   5 LRCK toggles every 8 BCLK with 0xFFFF_0000 -> left sends 1111111 (7 bits), right 0000000, no hang.
//   6 Assert reset at bit 5 of left -> DACDAT 0 immediately; after release, lrise ignored; output resumes at next lfall.

Source files
------------

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: I2S DAC transmitter with a one-word stereo holding buffer, driven by codec-mastered BCLK/LRCK.
module audio_dac_serializer #(
  parameter int CH_W        = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              AUD_BCLK,
  input  logic              AUD_DACLRCK,
  input  logic [2*CH_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              AUD_DACDAT,
  output logic              frame_start,
  output logic              underrun
);
  localparam int CW = $clog2(CH_W + 2);
  typedef enum logic [1:0] {IDLE, WAIT_MSB, SHIFT, PAD} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync;
  logic bclk_d, lrck_d, bfall, lfall, lrise;
  logic [2*CH_W-1:0] hold_reg, frame_reg, frame_n;
  logic hold_full, accept;
  logic [CH_W-1:0] shift_reg, shift_n;
  logic [CW-1:0] bit_cnt, cnt_n;
  logic dac_n;
  assign bfall        = bclk_d & ~bclk_sync[SYNC_STAGES-1];
  assign lfall        = lrck_d & ~lrck_sync[SYNC_STAGES-1];
  assign lrise        = ~lrck_d & lrck_sync[SYNC_STAGES-1];
  assign sample_ready = ~hold_full;
  assign accept       = sample_valid & ~hold_full;
  // The left load uses the buffer as it stood before this cycle; a same-cycle accept waits for the next frame.
  assign frame_n      = lfall ? (hold_full ? hold_reg : '0) : frame_reg;
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      bclk_sync   <= '0;
      lrck_sync   <= '0;
      bclk_d      <= 1'b0;
      lrck_d      <= 1'b0;
      hold_reg    <= '0;
      hold_full   <= 1'b0;
      frame_reg   <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      AUD_DACDAT  <= 1'b0;
    end else begin
      bclk_sync   <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
      lrck_sync   <= {lrck_sync[SYNC_STAGES-2:0], AUD_DACLRCK};
      bclk_d      <= bclk_sync[SYNC_STAGES-1];
      lrck_d      <= lrck_sync[SYNC_STAGES-1];
      hold_reg    <= accept ? sample_in : hold_reg;
      hold_full   <= accept | (hold_full & ~lfall);
      frame_reg   <= frame_n;
      frame_start <= lfall & hold_full;
      underrun    <= lfall & ~hold_full;
      state       <= state_n;
      shift_reg   <= shift_n;
      bit_cnt     <= cnt_n;
      AUD_DACDAT  <= dac_n;
    end
  end
  // An LRCK edge outranks a coincident BCLK fall: that fall only reloads, the MSB goes out on the next one.
  always_comb begin
    state_n = state;
    shift_n = shift_reg;
    cnt_n   = bit_cnt;
    dac_n   = AUD_DACDAT;
    if (lfall || (lrise && state != IDLE)) begin
      state_n = WAIT_MSB;
      shift_n = lfall ? frame_n[2*CH_W-1:CH_W] : frame_reg[CH_W-1:0];
      cnt_n   = '0;
      dac_n   = 1'b0;
    end else if (bfall && state != IDLE) begin
      state_n = bit_cnt < CW'(CH_W) ? SHIFT : PAD;
      dac_n   = bit_cnt < CW'(CH_W) ? shift_reg[CH_W-1] : 1'b0;
      shift_n = bit_cnt < CW'(CH_W) ? {shift_reg[CH_W-2:0], 1'b0} : shift_reg;
      cnt_n   = bit_cnt < CW'(CH_W) ? bit_cnt + 1'b1 : CW'(CH_W + 1);
    end
  end
endmodule
